// File: rtl/kmap_sweep_pkg.sv
// Shared definitions for the K-map truth-table sweep controller and its evaluator.
package kmap_sweep_pkg;

   localparam int unsigned NUM_VEC = 16;
   localparam int unsigned IDX_W   = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      APPLY  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_e;

endpackage : kmap_sweep_pkg

// File: rtl/kmap_sweep_ctrl_eval.sv
// Combinational evaluator: f1 = b'd' + a'bd + abc' (sel=0), f2 = y'z + xy + wy (sel=1).
module kmap_eval
   import kmap_sweep_pkg::*;
(
   input  logic [IDX_W-1:0] vec,
   input  logic             sel,
   output logic             fout
);

   logic f1;
   logic f2;

   // vec[3] is the MSB input (a or w), vec[0] the LSB (d or z).
   always_comb begin
      f1   = (~vec[2] & ~vec[0])
           | (~vec[3] &  vec[2] &  vec[0])
           | ( vec[3] &  vec[2] & ~vec[1]);
      f2   = (~vec[1] &  vec[0])
           | ( vec[2] &  vec[1])
           | ( vec[3] &  vec[1]);
      fout = sel ? f2 : f1;
   end

endmodule : kmap_eval

// File: rtl/kmap_sweep_ctrl.sv
// Sweeps all 16 input vectors through kmap_eval, captures the observed truth table
// and compares it against an expected mask latched at start.
module kmap_sweep_ctrl
   import kmap_sweep_pkg::*;
#(
   parameter int unsigned SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sel,
   input  logic [15:0]      exp_mask,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [4:0]       err_cnt,
   output logic             first_err_vld,
   output logic [3:0]       first_err_idx,
   output logic [15:0]      obs_mask,
   output logic [3:0]       vec
);

   localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_VEC - 1);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               sel_q, sel_d;
   logic [15:0]        exp_q, exp_d;
   logic [4:0]         err_cnt_q, err_cnt_d;
   logic               fev_q, fev_d;
   logic [3:0]         fei_q, fei_d;
   logic [15:0]        obs_q, obs_d;
   logic               pass_q, pass_d;
   logic               fout;

   kmap_eval u_eval (
      .vec  (idx_q),
      .sel  (sel_q),
      .fout (fout)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      sel_d     = sel_q;
      exp_d     = exp_q;
      err_cnt_d = err_cnt_q;
      fev_d     = fev_q;
      fei_d     = fei_q;
      obs_d     = obs_q;
      pass_d    = pass_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               sel_d     = sel;
               exp_d     = exp_mask;
               err_cnt_d = '0;
               obs_d     = '0;
               fev_d     = 1'b0;
               fei_d     = '0;
               idx_d     = '0;
               cnt_d     = '0;
               state_d   = APPLY;
            end
         end
         APPLY: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = '0;
               state_d = SAMPLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         SAMPLE: begin
            obs_d[idx_q] = fout;
            if (fout != exp_q[idx_q]) begin
               err_cnt_d = err_cnt_q + 5'd1;
               if (!fev_q) begin
                  fev_d = 1'b1;
                  fei_d = idx_q;
               end
            end
            // pass is resolved here so it is already valid during the done pulse.
            if (idx_q == IDX_LAST) begin
               pass_d  = (err_cnt_d == 5'd0);
               state_d = DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = APPLY;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         cnt_q     <= '0;
         sel_q     <= 1'b0;
         exp_q     <= '0;
         err_cnt_q <= '0;
         fev_q     <= 1'b0;
         fei_q     <= '0;
         obs_q     <= '0;
         pass_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         sel_q     <= sel_d;
         exp_q     <= exp_d;
         err_cnt_q <= err_cnt_d;
         fev_q     <= fev_d;
         fei_q     <= fei_d;
         obs_q     <= obs_d;
         pass_q    <= pass_d;
      end
   end

   assign busy          = (state_q != IDLE);
   assign done          = (state_q == DONE);
   assign pass          = pass_q;
   assign err_cnt       = err_cnt_q;
   assign first_err_vld = fev_q;
   assign first_err_idx = fei_q;
   assign obs_mask      = obs_q;
   assign vec           = idx_q;

endmodule : kmap_sweep_ctrl

// File: tb/tb_kmap_sweep_ctrl.sv
// Scoreboard bench for kmap_sweep_ctrl: expected sweep results are queued at start
// and compared when done pulses.
module tb_kmap_sweep_ctrl;

   localparam int unsigned SETTLE = 1;
   localparam int unsigned LAT    = 16 * (SETTLE + 1) + 1;

   typedef struct {
      logic        pass;
      logic [4:0]  err;
      logic        fev;
      logic [3:0]  fei;
      logic [15:0] obs;
      int unsigned acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        sel;
   logic [15:0] exp_mask;
   logic        busy;
   logic        done;
   logic        pass;
   logic [4:0]  err_cnt;
   logic        first_err_vld;
   logic [3:0]  first_err_idx;
   logic [15:0] obs_mask;
   logic [3:0]  vec;

   int unsigned cyc     = 0;
   int unsigned n_check = 0;
   int unsigned n_err   = 0;
   exp_t        sb[$];
   exp_t        last_exp;

   kmap_sweep_ctrl #(.SETTLE(SETTLE)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .sel           (sel),
      .exp_mask      (exp_mask),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .err_cnt       (err_cnt),
      .first_err_vld (first_err_vld),
      .first_err_idx (first_err_idx),
      .obs_mask      (obs_mask),
      .vec           (vec)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_check++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
      end
   endtask

   function automatic exp_t model(input logic s, input logic [15:0] m);
      exp_t       e;
      logic [3:0] v;
      logic       f;
      e.obs = '0; e.err = '0; e.fev = 1'b0; e.fei = '0; e.acc = 0;
      for (int i = 0; i < 16; i++) begin
         v = 4'(i);
         if (!s) f = (~v[2] & ~v[0]) | (~v[3] & v[2] & v[0]) | (v[3] & v[2] & ~v[1]);
         else    f = (~v[1] & v[0]) | (v[2] & v[1]) | (v[3] & v[1]);
         e.obs[i] = f;
         if (f != m[i]) begin
            e.err = e.err + 5'd1;
            if (!e.fev) begin
               e.fev = 1'b1;
               e.fei = v;
            end
         end
      end
      e.pass = (e.err == 5'd0);
      return e;
   endfunction

   // Result monitor: every done pulse must match the oldest queued request.
   always @(negedge clk) begin
      exp_t e;
      if (done) begin
         if (sb.size() == 0) begin
            check("spurious_done", 32'(done), 32'd0);
         end else begin
            e = sb.pop_front();
            check("latency",  cyc - e.acc + 1, LAT);
            check("busy_at_done", 32'(busy), 32'd1);
            check("pass",     32'(pass), 32'(e.pass));
            check("err_cnt",  32'(err_cnt), 32'(e.err));
            check("first_err_vld", 32'(first_err_vld), 32'(e.fev));
            if (e.fev) check("first_err_idx", 32'(first_err_idx), 32'(e.fei));
            check("obs_mask", 32'(obs_mask), 32'(e.obs));
            last_exp = e;
         end
      end
   end

   task automatic start_sweep(input logic s, input logic [15:0] m, input bit push);
      exp_t e;
      @(negedge clk);
      start    = 1'b1;
      sel      = s;
      exp_mask = m;
      if (push) begin
         e     = model(s, m);
         e.acc = cyc + 1;
         sb.push_back(e);
      end
      @(negedge clk);
      start    = 1'b0;
      sel      = 1'($urandom);
      exp_mask = 16'($urandom);
   endtask

   task automatic wait_done(input int unsigned budget);
      int unsigned n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         check("done_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("hold_obs",  32'(obs_mask), 32'(last_exp.obs));
      check("hold_pass", 32'(pass), 32'(last_exp.pass));
   endtask

   task automatic wait_vec(input logic [3:0] v);
      int unsigned n = 0;
      while (!(busy && vec == v) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("wait_vec_timeout", 32'(busy && vec == v), 32'd1);
   endtask

   task automatic check_reset_state(input string pfx);
      check({pfx, "_busy"},  32'(busy), 32'd0);
      check({pfx, "_done"},  32'(done), 32'd0);
      check({pfx, "_pass"},  32'(pass), 32'd0);
      check({pfx, "_err"},   32'(err_cnt), 32'd0);
      check({pfx, "_fev"},   32'(first_err_vld), 32'd0);
      check({pfx, "_fei"},   32'(first_err_idx), 32'd0);
      check({pfx, "_obs"},   32'(obs_mask), 32'd0);
      check({pfx, "_vec"},   32'(vec), 32'd0);
   endtask

   initial begin
      int unsigned n;
      rst = 1'b1; start = 1'b0; sel = 1'b0; exp_mask = '0;
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;

      // Directed sweeps: both functions, passing and failing masks.
      start_sweep(1'b0, 16'h35A5, 1'b1); wait_done(200);
      start_sweep(1'b1, 16'hEEE2, 1'b1); wait_done(200);
      start_sweep(1'b0, 16'h35A4, 1'b1); wait_done(200);
      start_sweep(1'b1, 16'h0000, 1'b1); wait_done(200);
      start_sweep(1'b0, 16'hFFFF, 1'b1); wait_done(200);

      // Start re-pulsed mid-sweep must be ignored.
      start_sweep(1'b0, 16'h35A5, 1'b1);
      wait_vec(4'd3);
      start_sweep(1'b1, 16'h0000, 1'b0);
      wait_vec(4'd15);
      start_sweep(1'b1, 16'h1234, 1'b0);
      wait_done(200);

      // Start during the done cycle must be ignored.
      start_sweep(1'b1, 16'hEEE3, 1'b1);
      n = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", 32'(done), 32'd1);
      start = 1'b1; sel = 1'b0; exp_mask = 16'h0000;
      @(negedge clk);
      start = 1'b0;
      check("start_in_done_ignored", 32'(busy), 32'd0);
      @(negedge clk);
      check("still_idle", 32'(busy), 32'd0);

      // Reset during APPLY of vector 7 discards the sweep.
      start_sweep(1'b0, 16'h35A5, 1'b1);
      wait_vec(4'd7);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      check_reset_state("midrst");
      rst = 1'b0;
      repeat (40) @(negedge clk);
      start_sweep(1'b0, 16'h35A5, 1'b1); wait_done(200);

      // Random masks.
      for (int k = 0; k < 4; k++) begin
         start_sweep(1'($urandom), 16'($urandom), 1'b1);
         wait_done(200);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_check);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1);
   end

endmodule : tb_kmap_sweep_ctrl

// File: doc/kmap_sweep_ctrl.md
KMAP_SWEEP_CTRL -- requirements
Module: kmap_sweep_ctrl

Interface
REQ-001 SHALL have parameter: SETTLE, default 1, number of cycles (range 1..15) each input vector is held before the result is sampled.
REQ-002 SHALL have port: clk  in  1  single clock, all state updates on the rising edge.
REQ-003 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  in  1  request to begin a 16-vector truth-table sweep.
REQ-005 SHALL have port: sel  in  1  function select: 0 = f1(a,b,c,d), 1 = f2(w,x,y,z).
REQ-006 SHALL have port: exp_mask  in  16  expected truth table; bit i is the expected output for vector i.
REQ-007 SHALL have port: busy  out  1  high from start acceptance until done is asserted.
REQ-008 SHALL have port: done  out  1  one-cycle completion pulse.
REQ-009 SHALL have port: pass  out  1  high when the last sweep had zero mismatches.
REQ-010 SHALL have port: err_cnt  out  5  mismatch count for the last sweep (0..16).
REQ-011 SHALL have port: first_err_vld  out  1  at least one mismatch was recorded.
REQ-012 SHALL have port: first_err_idx  out  4  index of the lowest mismatching vector.
REQ-013 SHALL have port: obs_mask  out  16  captured truth table; bit i is the observed output for vector i.
REQ-014 SHALL have port: vec  out  4  vector currently applied to the evaluator.

Function
REQ-015 SHALL map vector index i to {a,b,c,d} (sel=0) or {w,x,y,z} (sel=1), with bit3 as the MSB (a or w).
REQ-016 SHALL evaluate f1 = b'd' + a'bd + abc' and f2 = y'z + xy + wy.
REQ-017 SHALL implement FSM states IDLE, APPLY, SAMPLE, DONE.
REQ-018 IDLE: start=1 SHALL latch sel and exp_mask, clear err_cnt, obs_mask, first_err_vld and first_err_idx, set idx=0, and go to APPLY.
REQ-019 APPLY: SHALL drive vec=idx for exactly SETTLE cycles, then go to SAMPLE.
REQ-020 SAMPLE (one cycle): SHALL write the evaluator output into obs_mask[idx] and compare it against latched exp_mask[idx].
REQ-021 SAMPLE: on a mismatch, SHALL increment err_cnt and, if first_err_vld=0, set first_err_vld=1 and first_err_idx=idx.
REQ-022 SAMPLE: if idx=15, SHALL go to DONE; otherwise SHALL increment idx and go to APPLY.
REQ-023 DONE: SHALL assert done for exactly one cycle, set pass=(err_cnt==0), and return to IDLE.
REQ-024 done SHALL assert exactly 16*(SETTLE+1)+1 cycles after the cycle in which start was accepted (33 cycles for SETTLE=1).
REQ-025 busy SHALL be high in the APPLY, SAMPLE and DONE states.
REQ-026 start SHALL be ignored while busy; sel and exp_mask SHALL be sampled only at acceptance.
REQ-027 Results (pass, err_cnt, first_err_*, obs_mask) SHALL hold until the next accepted start.
REQ-028 err_cnt SHALL be 5 bits wide, with no wrap and no saturation required (maximum value 16).
REQ-029 start asserted in the same cycle as DONE SHALL be ignored; a new sweep is accepted in IDLE only.

Reset
REQ-030 rst=1 SHALL force, on the next edge: state=IDLE, idx=0, vec=0, busy=0, done=0, pass=0, err_cnt=0, first_err_vld=0, first_err_idx=0, obs_mask=0.
REQ-031 rst SHALL take priority over start and over any in-progress sweep; a partial sweep SHALL be discarded with no done pulse.

Structure
REQ-032 SHALL place the state enum, NUM_VEC=16 and IDX_W=4 in the shared package kmap_sweep_pkg.
REQ-033 SHALL instantiate one combinational sub-module, kmap_eval (inputs vec and sel; output fout), which implements REQ-015/REQ-016.
REQ-034 The controller SHALL contain all sequential logic; kmap_eval SHALL contain none.

Verification
REQ-035 sel=0, exp_mask=0x35A5, SETTLE=1 -> done 33 cycles after start; pass=1, err_cnt=0, obs_mask=0x35A5.
REQ-036 sel=1, exp_mask=0xEEE2 -> pass=1, err_cnt=0, obs_mask=0xEEE2.
REQ-037 sel=0, exp_mask=0x35A4 -> pass=0, err_cnt=1, first_err_vld=1, first_err_idx=0.
REQ-038 sel=1, exp_mask=0x0000 -> err_cnt=10, first_err_idx=1, obs_mask=0xEEE2.
REQ-039 rst asserted during APPLY of vector 7 -> all outputs at reset values next cycle, no done pulse; a following start with sel=0, exp_mask=0x35A5 passes.
REQ-040 start re-pulsed at vectors 3 and 15 with a different sel and exp_mask -> ignored; done timing and results match the first request.
